wb_gpio_irq: RTL and testbench

WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

---
 rtl/wb_gpio_irq_pkg.sv | 40 ++++
 rtl/wb_gpio_irq_if.sv | 30 +++
 rtl/wb_gpio_irq_sync_edge.sv | 47 ++++
 rtl/wb_gpio_irq.sv | 175 +++++++++++++++++
 tb/tb_wb_gpio_irq.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_gpio_irq_pkg.sv
// ---------------------------------------------------------------------------
// wb_gpio_pkg
// Shared constants for the Wishbone GPIO block with edge interrupts:
//   - byte offsets of the eight word registers and their 3-bit word index
//   - legal bounds of the WIDTH and SYNC_STAGES parameters
//   - lane_mask(): expands Wishbone byte selects into a 32-bit bit mask
// ---------------------------------------------------------------------------
package wb_gpio_pkg;

  localparam int unsigned WIDTH_MIN       = 32'd1;
  localparam int unsigned WIDTH_MAX       = 32'd32;
  localparam int unsigned SYNC_STAGES_MIN = 32'd2;
  localparam int unsigned SYNC_STAGES_MAX = 32'd4;

  localparam logic [31:0] OFS_OUT    = 32'h0000_0000;
  localparam logic [31:0] OFS_IN     = 32'h0000_0004;
  localparam logic [31:0] OFS_DIR    = 32'h0000_0008;
  localparam logic [31:0] OFS_IE     = 32'h0000_000C;
  localparam logic [31:0] OFS_EDGE   = 32'h0000_0010;
  localparam logic [31:0] OFS_BOTH   = 32'h0000_0014;
  localparam logic [31:0] OFS_PEND   = 32'h0000_0018;
  localparam logic [31:0] OFS_SETCLR = 32'h0000_001C;

  // Word index taken from address bits [4:2]
  typedef enum logic [2:0] {
    REG_OUT    = 3'd0,
    REG_IN     = 3'd1,
    REG_DIR    = 3'd2,
    REG_IE     = 3'd3,
    REG_EDGE   = 3'd4,
    REG_BOTH   = 3'd5,
    REG_PEND   = 3'd6,
    REG_SETCLR = 3'd7
  } reg_idx_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// ---------------------------------------------------------------------------
// wb_gpio_irq_if
// Wishbone classic slave bus bundle for wb_gpio_irq.
//   wb_stb_i, wb_cyc_i, wb_we_i : strobe, cycle, write enable (master -> slave)
//   wb_adr_i[31:0]              : byte address
//   wb_sel_i[3:0]               : byte lane enables
//   wb_dat_i[31:0]              : write data
//   wb_dat_o[31:0]              : read data (slave -> master)
//   wb_ack_o                    : transfer acknowledge (slave -> master)
// ---------------------------------------------------------------------------
interface wb_gpio_irq_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_gpio_irq_sync_edge.sv
// ---------------------------------------------------------------------------
// gpio_sync_edge
// Brings asynchronous pins into the clock domain and detects edges.
//   clk, reset  : clock, asynchronous active-low reset
//   pin_i       : raw asynchronous pin values
//   sync_o      : synchroniser chain output (SYNC_STAGES flops deep)
//   rise_o      : one-cycle pulse, chain output went 0 -> 1
//   fall_o      : one-cycle pulse, chain output went 1 -> 0
// Chain and delay flop both reset to zero, so the detector is primed: no
// edge can be reported in the first cycle after reset release.
// ---------------------------------------------------------------------------
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;

  // Synchroniser chain plus one-cycle delayed copy of its output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 32'sd0; s < SYNC_STAGES; s++) begin
        chain_q[s] <= {WIDTH{1'b0}};
      end
      dly_q <= {WIDTH{1'b0}};
    end else begin
      chain_q[0] <= pin_i;
      for (int s = 32'sd1; s < SYNC_STAGES; s++) begin
        chain_q[s] <= chain_q[s-1];
      end
      dly_q <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~chain_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// ---------------------------------------------------------------------------
// wb_gpio_irq
// Wishbone-mapped GPIO block with per-pin direction and edge interrupts.
//   clk, reset     : clock, asynchronous active-low reset
//   wb (slave)     : Wishbone classic slave, one wait state, one-cycle ack
//   gpio_in        : asynchronous pin inputs
//   gpio_out       : OUT register
//   gpio_oe        : DIR register (1 drives the pin)
//   irq_o          : registered |(PEND & IE)
// Registers (byte offset): 00 OUT, 04 IN, 08 DIR, 0C IE, 10 EDGE,
// 14 BOTH, 18 PEND (write 1 to clear), 1C SETCLR (write only).
// ---------------------------------------------------------------------------
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  wb_gpio_irq_if.slave     wb,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  // SETCLR packs set and clear halves into one word, so it only fits 16 pins
  localparam bit SETCLR_EN = (WIDTH <= 32'sd16);

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, ie_q, ie_d;
  logic [WIDTH-1:0] edge_q, edge_d, both_q, both_d, pend_q, pend_d;
  logic             ack_q, ack_d, irq_q, irq_d;
  logic [31:0]      dat_q, dat_d, rd_s;
  logic [WIDTH-1:0] sync_s, rise_s, fall_s, hit_s, w1c_s;
  logic             req_s, wr_s;
  reg_idx_e         idx_s;
  logic             unused_adr_s;

  // Byte-lane merge restricted to implemented bits
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_v,
                                                   input logic [31:0]      new_v,
                                                   input logic [3:0]       sel);
    logic [31:0] m;
    m = lane_mask(sel);
    merge_lanes = (old_v & ~m[WIDTH-1:0]) | (new_v[WIDTH-1:0] & m[WIDTH-1:0]);
  endfunction

  // Set low half, clear high half; a bit named in both halves toggles
  function automatic logic [WIDTH-1:0] apply_setclr(input logic [WIDTH-1:0] old_v,
                                                    input logic [31:0]      d,
                                                    input logic [3:0]       sel);
    logic [31:0] m;
    logic [31:0] s32;
    logic [31:0] c32;
    m   = lane_mask(sel);
    s32 = {16'h0000, d[15:0]  & m[15:0]};
    c32 = {16'h0000, d[31:16] & m[31:16]};
    for (int i = 32'sd0; i < WIDTH; i++) begin
      apply_setclr[i] = (s32[i] & c32[i]) ? ~old_v[i] : (s32[i] | (old_v[i] & ~c32[i]));
    end
  endfunction

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (gpio_in),
    .sync_o (sync_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // ack_q blocks a new request in the cycle it is high, giving the 1-cycle pulse
  assign req_s        = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr_s         = req_s & wb.wb_we_i;
  assign idx_s        = reg_idx_e'(wb.wb_adr_i[4:2]);
  assign unused_adr_s = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  // BOTH overrides EDGE; EDGE=1 selects rising, EDGE=0 falling
  assign hit_s = (both_q & (rise_s | fall_s))
               | (~both_q & edge_q & rise_s)
               | (~both_q & ~edge_q & fall_s);

  assign wb.wb_ack_o = ack_q & wb.wb_stb_i & wb.wb_cyc_i;
  assign wb.wb_dat_o = dat_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq_o       = irq_q;

  // Read multiplexer, zero-extended to the bus width
  always_comb begin
    rd_s = 32'h0000_0000;
    case (idx_s)
      REG_OUT:    rd_s[WIDTH-1:0] = out_q;
      REG_IN:     rd_s[WIDTH-1:0] = sync_s;
      REG_DIR:    rd_s[WIDTH-1:0] = dir_q;
      REG_IE:     rd_s[WIDTH-1:0] = ie_q;
      REG_EDGE:   rd_s[WIDTH-1:0] = edge_q;
      REG_BOTH:   rd_s[WIDTH-1:0] = both_q;
      REG_PEND:   rd_s[WIDTH-1:0] = pend_q;
      REG_SETCLR: rd_s = 32'h0000_0000;
      default:    rd_s = 32'h0000_0000;
    endcase
  end

  // Next-state for registers, handshake, read data and interrupt
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ie_d   = ie_q;
    edge_d = edge_q;
    both_d = both_q;
    w1c_s  = {WIDTH{1'b0}};
    if (wr_s) begin
      case (idx_s)
        REG_OUT:  out_d  = merge_lanes(out_q,  wb.wb_dat_i, wb.wb_sel_i);
        REG_DIR:  dir_d  = merge_lanes(dir_q,  wb.wb_dat_i, wb.wb_sel_i);
        REG_IE:   ie_d   = merge_lanes(ie_q,   wb.wb_dat_i, wb.wb_sel_i);
        REG_EDGE: edge_d = merge_lanes(edge_q, wb.wb_dat_i, wb.wb_sel_i);
        REG_BOTH: both_d = merge_lanes(both_q, wb.wb_dat_i, wb.wb_sel_i);
        REG_PEND: w1c_s  = merge_lanes({WIDTH{1'b0}}, wb.wb_dat_i, wb.wb_sel_i);
        REG_SETCLR: begin
          if (SETCLR_EN) begin
            out_d = apply_setclr(out_q, wb.wb_dat_i, wb.wb_sel_i);
          end else begin
            out_d = out_q;
          end
        end
        default: out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end

    // A new edge wins over a same-cycle clear
    pend_d = (pend_q & ~w1c_s) | hit_s;
    irq_d  = |(pend_q & ie_q);
    ack_d  = req_s;

    if (req_s && !wb.wb_we_i) begin
      dat_d = rd_s;
    end else begin
      dat_d = dat_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= {WIDTH{1'b0}};
      dir_q  <= {WIDTH{1'b0}};
      ie_q   <= {WIDTH{1'b0}};
      edge_q <= {WIDTH{1'b0}};
      both_q <= {WIDTH{1'b0}};
      pend_q <= {WIDTH{1'b0}};
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
      dat_q  <= 32'h0000_0000;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ie_q   <= ie_d;
      edge_q <= edge_d;
      both_q <= both_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// ---------------------------------------------------------------------------
// tb_wb_gpio_irq
// Self-checking bench for wb_gpio_irq (WIDTH=8, SYNC_STAGES=2). A register
// model tracks OUT/DIR/IE/EDGE/BOTH/PEND from bus writes and pin changes.
// ---------------------------------------------------------------------------
module tb_wb_gpio_irq;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq_o;

  wb_gpio_irq_if bus ();

  wb_gpio_irq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit [7:0] m_out, m_dir, m_ie, m_edge, m_both, m_pend, pins;

  // ---------------- reference model ----------------
  function automatic bit [31:0] lanes(input bit [31:0] old_v, input bit [31:0] new_v,
                                      input bit [3:0] sel);
    bit [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic bit model_irq();
    return |(m_pend & m_ie);
  endfunction

  function automatic bit [31:0] exp_read(input bit [31:0] adr);
    case (adr[4:2])
      3'd0:    return {24'h0, m_out};
      3'd1:    return {24'h0, pins};
      3'd2:    return {24'h0, m_dir};
      3'd3:    return {24'h0, m_ie};
      3'd4:    return {24'h0, m_edge};
      3'd5:    return {24'h0, m_both};
      3'd6:    return {24'h0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input bit [31:0] adr, input bit [31:0] wd, input bit [3:0] sel);
    bit [31:0] m;
    m = lanes(32'h0, 32'hFFFF_FFFF, sel);
    case (adr[4:2])
      3'd0: m_out  = 8'(lanes({24'h0, m_out},  wd, sel));
      3'd2: m_dir  = 8'(lanes({24'h0, m_dir},  wd, sel));
      3'd3: m_ie   = 8'(lanes({24'h0, m_ie},   wd, sel));
      3'd4: m_edge = 8'(lanes({24'h0, m_edge}, wd, sel));
      3'd5: m_both = 8'(lanes({24'h0, m_both}, wd, sel));
      3'd6: m_pend = m_pend & ~8'(wd & m);
      3'd7: begin
        for (int i = 0; i < W; i++) begin
          bit s, c;
          s = wd[i] & m[i];
          c = wd[16+i] & m[16+i];
          if (s && c)  m_out[i] = ~m_out[i];
          else if (s)  m_out[i] = 1'b1;
          else if (c)  m_out[i] = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // pins settle from `pins` to nw with no bus activity in between
  task automatic model_pins(input bit [7:0] nw);
    for (int i = 0; i < W; i++)
      if (pins[i] != nw[i])
        if (m_both[i] || (m_edge[i] == nw[i])) m_pend[i] = 1'b1;
    pins = nw;
  endtask

  // ---------------- bus helpers (start and end at posedge+1) ----------------
  task automatic bus_idle();
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h0; bus.wb_sel_i = 4'h0; bus.wb_dat_i = 32'h0;
  endtask

  task automatic wb_xfer(input bit we, input bit [31:0] adr, input bit [31:0] wd,
                         input bit [3:0] sel, output bit [31:0] rd, output int waits);
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_sel_i = sel;  bus.wb_dat_i = wd;
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (bus.wb_ack_o !== 1'b1 && waits < 8);
    total++;
    if (bus.wb_ack_o !== 1'b1) begin
      bad++;
      $display("FAIL ack_timeout adr=%h got ack=%b want 1", adr, bus.wb_ack_o);
    end
    rd = bus.wb_dat_o;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input bit [31:0] adr, input bit [31:0] wd, input bit [3:0] sel);
    bit [31:0] rd; int w;
    wb_xfer(1'b1, adr, wd, sel, rd, w);
    model_write(adr, wd, sel);
  endtask

  task automatic wb_read(input bit [31:0] adr, output bit [31:0] rd);
    int w;
    wb_xfer(1'b0, adr, 32'h0, 4'h0, rd, w);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit [31:0] rd;
    bus_idle();
    gpio_in = '0; pins = '0;
    {m_out, m_dir, m_ie, m_edge, m_both, m_pend} = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    total++; if (irq_o !== 1'b0)   begin bad++; $display("FAIL reset_irq got %b want 0", irq_o); end
    total++; if (gpio_oe !== 8'h0) begin bad++; $display("FAIL reset_oe got %h want 00", gpio_oe); end
    total++; if (gpio_out !== 8'h0) begin bad++; $display("FAIL reset_out got %h want 00", gpio_out); end
    for (int a = 0; a < 8; a++) begin
      wb_read(32'(a * 4), rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL reset_read ofs=%h got %h want 0", a * 4, rd); end
    end
  endtask

  task automatic test_out_dir();
    bit [31:0] rd; int w;
    wb_xfer(1'b1, 32'h08, 32'h0000_00FF, 4'b0001, rd, w);
    model_write(32'h08, 32'h0000_00FF, 4'b0001);
    total++; if (w !== 1) begin bad++; $display("FAIL ack_latency got %0d edges want 1", w); end
    // OUT write with stb held past the ack to see the ack is one cycle wide
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h00; bus.wb_sel_i = 4'b0001; bus.wb_dat_i = 32'h0000_00A5;
    #1;
    total++; if (bus.wb_ack_o !== 1'b0) begin bad++; $display("FAIL ack_wait got %b want 0", bus.wb_ack_o); end
    @(posedge clk); #1;
    total++; if (bus.wb_ack_o !== 1'b1) begin bad++; $display("FAIL ack_high got %b want 1", bus.wb_ack_o); end
    @(posedge clk); #1;
    total++; if (bus.wb_ack_o !== 1'b0) begin bad++; $display("FAIL ack_one_cycle got %b want 0", bus.wb_ack_o); end
    bus_idle();
    @(posedge clk); #1;
    model_write(32'h00, 32'h0000_00A5, 4'b0001);
    total++; if (gpio_oe !== m_dir)  begin bad++; $display("FAIL gpio_oe got %h want %h", gpio_oe, m_dir); end
    total++; if (gpio_out !== m_out) begin bad++; $display("FAIL gpio_out got %h want %h", gpio_out, m_out); end
    wb_read(32'h00, rd);
    total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL out_read got %h want 000000a5", rd); end
  endtask

  task automatic test_edge_irq();
    bit [31:0] rd; bit exp;
    wb_write(32'h10, 32'h01, 4'hF);
    wb_write(32'h0C, 32'h01, 4'hF);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      @(posedge clk); #1;
      exp = (k >= S + 2);
      total++;
      if (irq_o !== exp) begin bad++; $display("FAIL irq_timing edge=%0d got %b want %b", k, irq_o, exp); end
    end
    model_pins(8'h01);
    wb_read(32'h18, rd);
    total++; if (rd !== exp_read(32'h18)) begin bad++; $display("FAIL pend_rise got %h want %h", rd, exp_read(32'h18)); end
    wb_read(32'h04, rd);
    total++; if (rd !== 32'h01) begin bad++; $display("FAIL in_read got %h want 00000001", rd); end
    wb_write(32'h18, 32'h01, 4'hF);
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", irq_o); end
  endtask

  task automatic test_both_w1c();
    bit [31:0] rd;
    gpio_in[3] = 1'b1;
    repeat (S + 3) @(posedge clk);
    #1;
    model_pins(8'h09);
    wb_write(32'h18, 32'hFF, 4'hF);
    wb_write(32'h14, 32'h08, 4'hF);
    // falling edge reaches the detector in the same cycle the clear is applied
    gpio_in[3] = 1'b0;
    repeat (S) @(posedge clk);
    #1;
    wb_write(32'h18, 32'h08, 4'h1);
    model_pins(8'h01);
    wb_read(32'h18, rd);
    total++; if (rd !== 32'h08) begin bad++; $display("FAIL set_beats_w1c got %h want 00000008", rd); end
    wb_write(32'h18, 32'h08, 4'h1);
    wb_read(32'h18, rd);
    total++; if (rd !== exp_read(32'h18)) begin bad++; $display("FAIL w1c_later got %h want %h", rd, exp_read(32'h18)); end
  endtask

  task automatic test_regs_random();
    bit [31:0] rd, adr, wd; bit [3:0] sel;
    bit [31:0] ofs [5] = '{32'h00, 32'h08, 32'h0C, 32'h10, 32'h14};
    for (int r = 0; r < 20; r++) begin
      adr = ofs[$urandom_range(0, 4)];
      wd  = $urandom;
      sel = 4'($urandom);
      wb_write(adr, wd, sel);
      wb_read(adr, rd);
      total++;
      if (rd !== exp_read(adr)) begin bad++; $display("FAIL reg_rw adr=%h sel=%b got %h want %h", adr, sel, rd, exp_read(adr)); end
      total++;
      if (irq_o !== model_irq()) begin bad++; $display("FAIL reg_irq got %b want %b", irq_o, model_irq()); end
    end
    total++; if (gpio_out !== m_out) begin bad++; $display("FAIL rand_out got %h want %h", gpio_out, m_out); end
    total++; if (gpio_oe !== m_dir)  begin bad++; $display("FAIL rand_oe got %h want %h", gpio_oe, m_dir); end
  endtask

  task automatic test_edges_random();
    bit [31:0] rd, msk; bit [7:0] nw;
    wb_write(32'h0C, $urandom, 4'h1);
    wb_write(32'h10, $urandom, 4'h1);
    wb_write(32'h14, $urandom & 32'h0F, 4'h1);
    for (int r = 0; r < 12; r++) begin
      nw = 8'($urandom);
      gpio_in = nw;
      repeat (S + 3) @(posedge clk);
      #1;
      model_pins(nw);
      wb_read(32'h04, rd);
      total++; if (rd !== {24'h0, nw}) begin bad++; $display("FAIL rand_in got %h want %h", rd, nw); end
      wb_read(32'h18, rd);
      total++; if (rd !== exp_read(32'h18)) begin bad++; $display("FAIL rand_pend got %h want %h", rd, exp_read(32'h18)); end
      total++; if (irq_o !== model_irq()) begin bad++; $display("FAIL rand_irq got %b want %b", irq_o, model_irq()); end
      if ($urandom_range(0, 1) == 1) begin
        msk = $urandom;
        wb_write(32'h18, msk, 4'hF);
        wb_read(32'h18, rd);
        total++; if (rd !== exp_read(32'h18)) begin bad++; $display("FAIL rand_w1c got %h want %h", rd, exp_read(32'h18)); end
      end
    end
  endtask

  task automatic test_setclr_reset();
    bit [31:0] rd;
    wb_write(32'h00, 32'h0F, 4'h1);
    wb_write(32'h1C, 32'h0003_00F0, 4'hF);
    wb_read(32'h00, rd);
    total++; if (rd !== 32'hFC) begin bad++; $display("FAIL setclr got %h want 000000fc", rd); end
    wb_write(32'h1C, 32'h0081_0081, 4'hF);
    wb_read(32'h00, rd);
    total++; if (rd !== exp_read(32'h00) || rd !== 32'h7D) begin bad++; $display("FAIL setclr_toggle got %h want 0000007d", rd); end
    wb_read(32'h1C, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL setclr_read got %h want 0", rd); end
    // reset while the master still holds stb
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h08; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h33;
    @(posedge clk); #1;
    total++; if (bus.wb_ack_o !== 1'b1) begin bad++; $display("FAIL pre_reset_ack got %b want 1", bus.wb_ack_o); end
    reset = 1'b0;
    #1;
    total++; if (bus.wb_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack_drop got %b want 0", bus.wb_ack_o); end
    bus_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    {m_out, m_dir, m_ie, m_edge, m_both, m_pend} = '0;
    @(posedge clk); #1;
    wb_read(32'h00, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_reset_out got %h want 0", rd); end
    total++; if (gpio_out !== 8'h0) begin bad++; $display("FAIL post_reset_pin got %h want 00", gpio_out); end
    total++; if (gpio_oe !== 8'h0) begin bad++; $display("FAIL post_reset_oe got %h want 00", gpio_oe); end
  endtask

  initial begin
    test_reset();
    test_out_dir();
    test_edge_irq();
    test_both_w1c();
    test_regs_random();
    test_edges_random();
    test_setclr_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
